// File: rtl/ripple_count_extender_if.sv
// Bus between the ripple-counter sampler and its user.
// Carries Q_IN/TARGET/CLR_ERR in, COUNT/VALID/WRAP/MATCH/SEQ_ERR out.
interface ripple_count_extender_if #(
  parameter int HI_WIDTH = 12
);
  logic [3:0]          Q_IN;
  logic [HI_WIDTH+3:0] TARGET;
  logic                CLR_ERR;
  logic [HI_WIDTH+3:0] COUNT;
  logic                VALID;
  logic                WRAP;
  logic                MATCH;
  logic                SEQ_ERR;

  modport master (
    output Q_IN, TARGET, CLR_ERR,
    input  COUNT, VALID, WRAP, MATCH, SEQ_ERR
  );

  modport slave (
    input  Q_IN, TARGET, CLR_ERR,
    output COUNT, VALID, WRAP, MATCH, SEQ_ERR
  );
endinterface

// File: rtl/ripple_count_extender.sv
// Extends a 4-bit ripple counter to HI_WIDTH+4 bits by counting wraps.
// Ports: CLK, RESET (sync, active-high), bus (slave: Q_IN, TARGET,
// CLR_ERR in; COUNT, VALID, WRAP, MATCH, SEQ_ERR out).
// Option: RIPPLE_EXT_SEQ_CHECK_EN enables illegal-step detection.
module ripple_count_extender #(
  parameter int HI_WIDTH = 12
) (
  input  logic                    CLK,
  input  logic                    RESET,
  ripple_count_extender_if.slave  bus
);

  logic [3:0]          prev, prev_n;
  logic [3:0]          lo, lo_n;
  logic [HI_WIDTH-1:0] hi, hi_n;
  logic                valid, valid_n;
  logic                wrap, wrap_n;
  logic                match, match_n;
  logic                seq_err, seq_err_n;
  logic                step;
  logic                err_set;
  logic [3:0]          d;

  assign d = bus.Q_IN - prev;

  always_comb begin
    prev_n  = prev;
    lo_n    = lo;
    hi_n    = hi;
    valid_n = valid;
    wrap_n  = 1'b0;
    step    = 1'b0;
    err_set = 1'b0;
    if (!valid) begin
      // first sample after reset is a plain load
      lo_n    = bus.Q_IN;
      prev_n  = bus.Q_IN;
      valid_n = 1'b1;
      step    = 1'b1;
    end else if (d != 4'd0) begin
      lo_n   = bus.Q_IN;
      prev_n = bus.Q_IN;
      step   = 1'b1;
`ifdef RIPPLE_EXT_SEQ_CHECK_EN
      if (d == 4'd1) begin
        if (prev == 4'hF) begin
          hi_n   = hi + HI_WIDTH'(1);
          wrap_n = 1'b1;
        end
      end else begin
        err_set = 1'b1;
      end
`else
      // any backward step is taken as a wrap
      if (bus.Q_IN < prev) begin
        hi_n   = hi + HI_WIDTH'(1);
        wrap_n = 1'b1;
      end
`endif
    end
    // only a fresh value can match, never a held one
    match_n = step && ({hi_n, lo_n} == bus.TARGET);
  end

`ifdef RIPPLE_EXT_SEQ_CHECK_EN
  always_comb begin
    seq_err_n = seq_err;
    if (err_set)
      seq_err_n = 1'b1;
    else if (bus.CLR_ERR)
      seq_err_n = 1'b0;
  end
`else
  logic unused_clr;
  logic unused_err_set;
  assign unused_clr     = bus.CLR_ERR;
  assign unused_err_set = err_set;
  assign seq_err_n      = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      prev    <= '0;
      lo      <= '0;
      hi      <= '0;
      valid   <= 1'b0;
      wrap    <= 1'b0;
      match   <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      prev    <= prev_n;
      lo      <= lo_n;
      hi      <= hi_n;
      valid   <= valid_n;
      wrap    <= wrap_n;
      match   <= match_n;
      seq_err <= seq_err_n;
    end
  end

  assign bus.COUNT   = {hi, lo};
  assign bus.VALID   = valid;
  assign bus.WRAP    = wrap;
  assign bus.MATCH   = match;
  assign bus.SEQ_ERR = seq_err;

endmodule

// File: doc/ripple_count_extender.md
# ripple_count_extender

- Synchronous consumer that sits directly downstream of the 4-bit negedge T-flip-flop ripple up counter.
- Samples the counter's 4-bit `Q` on the rising edge of `CLK`, after ripple has settled following the counter's falling-edge update.
- Extends the count to 16 bits by counting 4-bit wraps.
- Flags skipped or backward steps, and raises one-cycle pulses on wrap and on a programmable target match.

## Interface
Parameters:
- `HI_WIDTH`, default 12: width of the wrap (high) counter; `COUNT` width is `HI_WIDTH+4`.

Ports (one clock; reset is synchronous and active-high):
- `CLK`  input  1  system clock; all state updates on rising edge.
- `RESET`  input  1  synchronous, active-high reset.
- `Q_IN`  input  4  ripple counter output `Q[3:0]`.
- `TARGET`  input  HI_WIDTH+4  match value for `MATCH`.
- `CLR_ERR`  input  1  clears sticky `SEQ_ERR`.
- `COUNT`  output  HI_WIDTH+4  extended count `{hi, lo}`.
- `VALID`  output  1  high once the first post-reset sample is taken.
- `WRAP`  output  1  one-cycle pulse on a 15→0 step.
- `MATCH`  output  1  one-cycle pulse when `COUNT` changes to equal `TARGET`.
- `SEQ_ERR`  output  1  sticky; set on an illegal step.

## Operation
- Internal state: `prev` (4 bit), `hi` (HI_WIDTH bit), `lo` (4 bit), `VALID`, `SEQ_ERR`.
- **RESET=1 at a rising edge:**
  - `COUNT`, `prev`, `VALID`, `WRAP`, `MATCH` and `SEQ_ERR` are set to 0.
  - Reset overrides every other input.
  - Reset mid-operation discards `hi` entirely.
- **First edge with RESET=0 (VALID=0):**
  - `lo` and `prev` load `Q_IN`.
  - `hi` stays 0.
  - `VALID` becomes 1.
  - No `WRAP`, no `SEQ_ERR`.
  - `MATCH` is evaluated normally, because the load counts as a change.
- **Subsequent edges:** compute `d = (Q_IN − prev) mod 16`.
  - d = 0: hold all state; `WRAP` = 0, `MATCH` = 0.
  - d = 1: `lo` and `prev` load `Q_IN`. If `prev` = 15 (so `Q_IN` = 0), `hi` increments and `WRAP` pulses.
  - d ≥ 2: illegal step.
    - `SEQ_ERR` sets to 1.
    - `lo` and `prev` resync to `Q_IN`; `hi` is unchanged.
    - No `WRAP`, even if the value crossed 0.
- **`hi` overflow:** `hi` wraps from 2^HI_WIDTH−1 to 0 with no flag, so `COUNT` wraps from 0xFFFF to 0x0000 at the default width.
- **MATCH:**
  - Asserted for the single cycle in which the registered `COUNT` takes a new value equal to `TARGET`.
  - Not re-asserted while `COUNT` holds.
  - A `TARGET` change while `COUNT` is static does not pulse `MATCH`.
- **SEQ_ERR:**
  - Cleared by `CLR_ERR` = 1.
  - If a new illegal step and `CLR_ERR` occur in the same cycle, the error wins and `SEQ_ERR` stays 1.

## Timing
- Latency is 1 cycle: `Q_IN` sampled at rising edge n appears on `COUNT` after edge n.
- `WRAP` and `MATCH` are registered and are high in the same cycle as the `COUNT` value that caused them.
- `Q_IN` must be stable for setup before the rising edge. The upstream counter changes on the falling edge, so at most half a cycle of ripple settling is budgeted.
- With `T` = 1 upstream, d = 1 every cycle, and `WRAP` pulses once every 16 cycles.

## Configuration
- Macro: `RIPPLE_EXT_SEQ_CHECK_EN`.
- **Defined:** sequence checking is as described in Operation.
- **Undefined:**
  - `SEQ_ERR` is tied to 0 and `CLR_ERR` is ignored.
  - Every edge with `Q_IN` ≠ `prev` loads `lo` and `prev`.
  - `hi` increments, and `WRAP` pulses, whenever `Q_IN` < `prev`, so any backward step is treated as a wrap.
  - d = 0 still holds.

## Test plan
- **Reset then free run:**
  - Stimulus: `RESET` = 1 for 2 edges, then `Q_IN` steps 0,1,2,…
  - During reset: all outputs 0.
  - First edge after release: `VALID` = 1, `COUNT` = 0x0000.
  - `COUNT` then tracks `Q_IN`; after 16 steps `COUNT` = 0x0010 with `WRAP` high for exactly that cycle.
- **Hold:**
  - Stimulus: `Q_IN` held at 5 for 4 edges.
  - Required: `COUNT` stays 0x0005; `WRAP` = 0 and `MATCH` = 0 throughout.
- **Match:**
  - Stimulus: `TARGET` = 0x0023, free run from 0.
  - Required: `MATCH` pulses exactly once, in the cycle `COUNT` = 0x0023.
  - Required: no pulse when `TARGET` is changed to 0x0023 while `COUNT` is already held at 0x0023.
- **Skip error (macro defined):**
  - Stimulus: `Q_IN` 14 → 1.
  - Required: `SEQ_ERR` = 1, `lo` = 1, `hi` unchanged, `WRAP` = 0.
  - Then `CLR_ERR` together with another skip (1→4) leaves `SEQ_ERR` = 1; `CLR_ERR` alone then clears it.
- **Skip without macro:**
  - Stimulus: `Q_IN` 14 → 1.
  - Required: `hi` increments, `WRAP` pulses, `SEQ_ERR` stays 0.
- **Overflow and mid-run reset:**
  - Stimulus: run `COUNT` to 0xFFFF, then one more step.
  - Required: `COUNT` = 0x0000 with `WRAP` = 1.
  - Then `RESET` at `COUNT` = 0x0037: `COUNT` and `VALID` are 0 on the next cycle, and the first sample after release reloads `lo` from `Q_IN` with `hi` = 0.
